// File: rtl/bus_cycle_ctrl_if.sv
// Requester and memory/IO bus signals of the bus cycle controller.
// master: the controller side; slave: requester plus memory/IO model side.
interface bus_cycle_ctrl_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 8
);
  logic              REQ;
  logic              REQ_WR;
  logic              REQ_MEM;
  logic [ADDR_W-1:0] REQ_ADDR;
  logic [DATA_W-1:0] REQ_WDATA;
  logic              ACK;
  logic              BUSY;
  logic              DONE;
  logic [DATA_W-1:0] RDATA;
  logic              ERR;
  logic              READY;
  logic              ALE;
  logic              RD;
  logic              WR;
  logic              IOM;
  logic              CS;
  logic [ADDR_W-1:0] Address;
  logic [DATA_W-1:0] DataOut;
  logic [DATA_W-1:0] Data;

  modport master (
    input  REQ, REQ_WR, REQ_MEM, REQ_ADDR, REQ_WDATA, READY, Data,
    output ACK, BUSY, DONE, RDATA, ERR, ALE, RD, WR, IOM, CS, Address, DataOut
  );

  modport slave (
    output REQ, REQ_WR, REQ_MEM, REQ_ADDR, REQ_WDATA, READY, Data,
    input  ACK, BUSY, DONE, RDATA, ERR, ALE, RD, WR, IOM, CS, Address, DataOut
  );
endinterface

// File: rtl/bus_cycle_ctrl.sv
// 8086-style T1..T4 bus cycle controller with READY-driven wait states.
// Define BUS_TIMEOUT_EN to abort a cycle after TIMEOUT consecutive wait states.
module bus_cycle_ctrl #(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 8
`ifdef BUS_TIMEOUT_EN
  , parameter int TIMEOUT = 16
`endif
) (
  input  logic             CLK,
  input  logic             RESET,
  bus_cycle_ctrl_if.master bus
);

  typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_T3, S_TW, S_T4} state_e;

  localparam logic [ADDR_W-1:0] IO_MASK = ADDR_W'({16{1'b1}});

  state_e              state_q, state_d;
  logic                req_wr_q, req_wr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                ale_q, ale_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic                iom_q, iom_d;
  logic                cs_q, cs_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                strobe;
  logic                in_wait;
  logic                tmo_hit;

  assign in_wait = (state_q == S_T3) || (state_q == S_TW);

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             err_q, err_d;

  // Abort on the TW cycle that would push the wait count to TIMEOUT.
  assign tmo_hit = (state_q == S_TW) && !bus.READY &&
                   (wait_cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q == S_T2)
      wait_cnt_d = '0;
    else if (state_q == S_TW && !bus.READY)
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    err_d = tmo_hit;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  assign bus.ERR = err_q;
`else
  assign tmo_hit = 1'b0;
  assign bus.ERR = 1'b0;
`endif

  // State register
  always_ff @(posedge CLK) begin
    if (!RESET) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:     if (bus.REQ) state_d = S_T1;
      S_T1:       state_d = S_T2;
      S_T2:       state_d = S_T3;
      S_T3, S_TW: state_d = (bus.READY || tmo_hit) ? S_T4 : S_TW;
      S_T4:       state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Output logic: bus outputs are registered from the next state so that
  // strobes switch cleanly on the same edge as the state.
  always_comb begin
    req_wr_d = req_wr_q;
    wdata_d  = wdata_q;
    addr_d   = addr_q;
    iom_d    = iom_q;
    dout_d   = dout_q;
    rdata_d  = rdata_q;

    strobe = (state_d == S_T2) || (state_d == S_T3) || (state_d == S_TW);
    ale_d  = (state_d == S_T1);
    cs_d   = (state_d == S_T1) || strobe;
    rd_d   = !(strobe && !req_wr_q);
    wr_d   = !(strobe && req_wr_q);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_T4);

    if (state_q == S_IDLE && bus.REQ) begin
      req_wr_d = bus.REQ_WR;
      wdata_d  = bus.REQ_WDATA;
      iom_d    = bus.REQ_MEM;
      addr_d   = bus.REQ_MEM ? bus.REQ_ADDR : (bus.REQ_ADDR & IO_MASK);
    end

    if (state_q == S_T1 && req_wr_q)
      dout_d = wdata_q;

    if (in_wait && bus.READY && !req_wr_q)
      rdata_d = bus.Data;
    else if (tmo_hit && !req_wr_q)
      rdata_d = '1;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      req_wr_q <= 1'b0;
      wdata_q  <= '0;
      ale_q    <= 1'b0;
      rd_q     <= 1'b1;
      wr_q     <= 1'b1;
      iom_q    <= 1'b0;
      cs_q     <= 1'b0;
      addr_q   <= '0;
      dout_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rdata_q  <= '0;
    end else begin
      req_wr_q <= req_wr_d;
      wdata_q  <= wdata_d;
      ale_q    <= ale_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      iom_q    <= iom_d;
      cs_q     <= cs_d;
      addr_q   <= addr_d;
      dout_q   <= dout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rdata_q  <= rdata_d;
    end
  end

  // ACK is masked during reset so a held REQ is never reported as taken.
  assign bus.ACK     = bus.REQ && RESET && (state_q == S_IDLE);
  assign bus.BUSY    = busy_q;
  assign bus.DONE    = done_q;
  assign bus.RDATA   = rdata_q;
  assign bus.ALE     = ale_q;
  assign bus.RD      = rd_q;
  assign bus.WR      = wr_q;
  assign bus.IOM     = iom_q;
  assign bus.CS      = cs_q;
  assign bus.Address = addr_q;
  assign bus.DataOut = dout_q;

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Directed bench for bus_cycle_ctrl: inputs change and outputs are sampled on negedge.
// Control word layout: {ALE, RD, WR, IOM, CS, BUSY, DONE, ERR}.
module tb_bus_cycle_ctrl;
  localparam int ADDR_W = 20;
  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   errors  = 0;

  bus_cycle_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bif ();

  bus_cycle_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .CLK  (clk),
    .RESET(rst_n),
    .bus  (bif.master)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ctl();
    return {bif.ALE, bif.RD, bif.WR, bif.IOM, bif.CS, bif.BUSY, bif.DONE, bif.ERR};
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic issue(input logic wr, input logic mem,
                       input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bif.REQ       = 1'b1;
    bif.REQ_WR    = wr;
    bif.REQ_MEM   = mem;
    bif.REQ_ADDR  = a;
    bif.REQ_WDATA = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    issue(1'b1, 1'b1, 20'hFFFFF, 8'hFF);
    bif.READY = 1'b1;
    bif.Data  = 8'h00;
    step();
    step();
    vectors++; if (ctl() !== 8'b0110_0000) begin errors++; $display("FAIL rst_ctl got %b want %b", ctl(), 8'b0110_0000); end
    vectors++; if (bif.ACK !== 1'b0) begin errors++; $display("FAIL rst_ack got %b want 0", bif.ACK); end
    vectors++; if (bif.Address !== 20'h0) begin errors++; $display("FAIL rst_addr got %h want 00000", bif.Address); end
    vectors++; if (bif.DataOut !== 8'h00 || bif.RDATA !== 8'h00) begin errors++; $display("FAIL rst_data got dout=%h rdata=%h want 00/00", bif.DataOut, bif.RDATA); end
    bif.REQ = 1'b0;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_mem_write();
    issue(1'b1, 1'b1, 20'h12345, 8'hA5);
    bif.READY = 1'b1;
    #1;
    vectors++; if (bif.ACK !== 1'b1) begin errors++; $display("FAIL mw_ack got %b want 1", bif.ACK); end
    step();
    bif.REQ = 1'b0; bif.REQ_ADDR = '0; bif.REQ_WDATA = '0;
    vectors++; if (ctl() !== 8'b1111_1100) begin errors++; $display("FAIL mw_t1_ctl got %b want %b", ctl(), 8'b1111_1100); end
    vectors++; if (bif.Address !== 20'h12345) begin errors++; $display("FAIL mw_t1_addr got %h want 12345", bif.Address); end
    step();
    vectors++; if (ctl() !== 8'b0101_1100) begin errors++; $display("FAIL mw_t2_ctl got %b want %b", ctl(), 8'b0101_1100); end
    vectors++; if (bif.DataOut !== 8'hA5) begin errors++; $display("FAIL mw_t2_dout got %h want a5", bif.DataOut); end
    step();
    vectors++; if (ctl() !== 8'b0101_1100) begin errors++; $display("FAIL mw_t3_ctl got %b want %b", ctl(), 8'b0101_1100); end
    step();
    vectors++; if (ctl() !== 8'b0111_0110) begin errors++; $display("FAIL mw_t4_ctl got %b want %b", ctl(), 8'b0111_0110); end
    vectors++; if (bif.Address !== 20'h12345) begin errors++; $display("FAIL mw_t4_addr got %h want 12345", bif.Address); end
    step();
    vectors++; if (ctl() !== 8'b0111_0000) begin errors++; $display("FAIL mw_idle_ctl got %b want %b", ctl(), 8'b0111_0000); end
    vectors++; if (bif.DataOut !== 8'hA5) begin errors++; $display("FAIL mw_idle_dout got %h want a5", bif.DataOut); end
  endtask

  task automatic test_io_read();
    issue(1'b0, 1'b0, 20'hF1234, 8'h00);
    bif.READY = 1'b1;
    bif.Data  = 8'h3C;
    #1;
    vectors++; if (bif.ACK !== 1'b1) begin errors++; $display("FAIL ior_ack got %b want 1", bif.ACK); end
    step();
    bif.REQ = 1'b0;
    vectors++; if (ctl() !== 8'b1110_1100) begin errors++; $display("FAIL ior_t1_ctl got %b want %b", ctl(), 8'b1110_1100); end
    vectors++; if (bif.Address !== 20'h01234) begin errors++; $display("FAIL ior_t1_addr got %h want 01234", bif.Address); end
    step();
    vectors++; if (ctl() !== 8'b0010_1100) begin errors++; $display("FAIL ior_t2_ctl got %b want %b", ctl(), 8'b0010_1100); end
    step();
    vectors++; if (ctl() !== 8'b0010_1100) begin errors++; $display("FAIL ior_t3_ctl got %b want %b", ctl(), 8'b0010_1100); end
    step();
    bif.Data = 8'hEE;
    vectors++; if (ctl() !== 8'b0110_0110) begin errors++; $display("FAIL ior_t4_ctl got %b want %b", ctl(), 8'b0110_0110); end
    vectors++; if (bif.RDATA !== 8'h3C) begin errors++; $display("FAIL ior_t4_rdata got %h want 3c", bif.RDATA); end
    step();
    vectors++; if (ctl() !== 8'b0110_0000 || bif.RDATA !== 8'h3C) begin errors++; $display("FAIL ior_idle got ctl=%b rdata=%h want 01100000/3c", ctl(), bif.RDATA); end
  endtask

  task automatic test_write_keeps_rdata();
    issue(1'b1, 1'b0, 20'h00042, 8'h77);
    bif.READY = 1'b1;
    bif.Data  = 8'h99;
    step();
    bif.REQ = 1'b0;
    step();
    vectors++; if (ctl() !== 8'b0100_1100 || bif.DataOut !== 8'h77) begin errors++; $display("FAIL iow_t2 got ctl=%b dout=%h want 01001100/77", ctl(), bif.DataOut); end
    step();
    step();
    vectors++; if (ctl() !== 8'b0110_0110) begin errors++; $display("FAIL iow_t4_ctl got %b want %b", ctl(), 8'b0110_0110); end
    vectors++; if (bif.RDATA !== 8'h3C) begin errors++; $display("FAIL iow_rdata_kept got %h want 3c", bif.RDATA); end
    step();
  endtask

  task automatic test_wait_states();
    issue(1'b0, 1'b1, 20'h0ABCD, 8'h00);
    bif.READY = 1'b0;
    bif.Data  = 8'h11;
    step();
    bif.REQ = 1'b0;
    step();
    step();
    vectors++; if (ctl() !== 8'b0011_1100) begin errors++; $display("FAIL ws_t3_ctl got %b want %b", ctl(), 8'b0011_1100); end
    step();
    bif.Data = 8'h22;
    vectors++; if (ctl() !== 8'b0011_1100) begin errors++; $display("FAIL ws_tw1_ctl got %b want %b", ctl(), 8'b0011_1100); end
    step();
    vectors++; if (ctl() !== 8'b0011_1100) begin errors++; $display("FAIL ws_tw2_ctl got %b want %b", ctl(), 8'b0011_1100); end
    bif.READY = 1'b1;
    bif.Data  = 8'h5A;
    step();
    bif.Data = 8'h99;
    vectors++; if (ctl() !== 8'b0111_0110) begin errors++; $display("FAIL ws_t4_ctl got %b want %b", ctl(), 8'b0111_0110); end
    vectors++; if (bif.RDATA !== 8'h5A) begin errors++; $display("FAIL ws_rdata got %h want 5a", bif.RDATA); end
    step();
    vectors++; if (bif.DONE !== 1'b0 || bif.RDATA !== 8'h5A) begin errors++; $display("FAIL ws_idle got done=%b rdata=%h want 0/5a", bif.DONE, bif.RDATA); end
  endtask

  task automatic test_back_to_back();
    logic [9:0] ack_seen, done_seen;
    ack_seen  = '0;
    done_seen = '0;
    bif.READY = 1'b1;
    issue(1'b1, 1'b1, 20'h00100, 8'h01);
    #1;
    for (int i = 0; i < 10; i++) begin
      ack_seen[i]  = bif.ACK;
      done_seen[i] = bif.DONE;
      if (i == 0) begin bif.REQ_ADDR = 20'h00200; bif.REQ_WDATA = 8'h02; end
      if (i == 9) bif.REQ = 1'b0;
      step();
    end
    vectors++; if (ack_seen !== 10'b00001_00001) begin errors++; $display("FAIL b2b_ack got %b want %b", ack_seen, 10'b00001_00001); end
    vectors++; if (done_seen !== 10'b10000_10000) begin errors++; $display("FAIL b2b_done got %b want %b", done_seen, 10'b10000_10000); end
    vectors++; if (bif.Address !== 20'h00200 || bif.DataOut !== 8'h02) begin errors++; $display("FAIL b2b_second got addr=%h dout=%h want 00200/02", bif.Address, bif.DataOut); end
  endtask

  task automatic test_reset_mid();
    int dcount;
    issue(1'b1, 1'b1, 20'h0BEEF, 8'h5C);
    bif.READY = 1'b1;
    step();
    bif.REQ = 1'b0;
    step();
    vectors++; if (ctl() !== 8'b0101_1100) begin errors++; $display("FAIL rm_t2_ctl got %b want %b", ctl(), 8'b0101_1100); end
    rst_n = 1'b0;
    step();
    vectors++; if (ctl() !== 8'b0110_0000) begin errors++; $display("FAIL rm_ctl got %b want %b", ctl(), 8'b0110_0000); end
    vectors++; if (bif.Address !== 20'h0 || bif.DataOut !== 8'h00) begin errors++; $display("FAIL rm_bus got addr=%h dout=%h want 00000/00", bif.Address, bif.DataOut); end
    rst_n = 1'b1;
    dcount = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bif.DONE === 1'b1) dcount++;
    end
    vectors++; if (dcount !== 0) begin errors++; $display("FAIL rm_no_done got %0d done pulses want 0", dcount); end
    issue(1'b0, 1'b0, 20'h00055, 8'h00);
    bif.Data = 8'hC3;
    #1;
    vectors++; if (bif.ACK !== 1'b1) begin errors++; $display("FAIL rm_ack got %b want 1", bif.ACK); end
    step();
    bif.REQ = 1'b0;
    step();
    step();
    step();
    vectors++; if (ctl() !== 8'b0110_0110 || bif.RDATA !== 8'hC3) begin errors++; $display("FAIL rm_next got ctl=%b rdata=%h want 01100110/c3", ctl(), bif.RDATA); end
    step();
  endtask

  task automatic test_timeout();
    issue(1'b0, 1'b1, 20'h00777, 8'h00);
    bif.READY = 1'b0;
    bif.Data  = 8'h12;
`ifdef BUS_TIMEOUT_EN
    begin
      int done_cyc;
      logic err_at;
      logic [7:0] rd_at;
      done_cyc = -1;
      err_at   = 1'b0;
      rd_at    = 8'h00;
      for (int i = 1; i <= 40 && done_cyc < 0; i++) begin
        step();
        if (i == 1) bif.REQ = 1'b0;
        if (bif.DONE === 1'b1) begin done_cyc = i; err_at = bif.ERR; rd_at = bif.RDATA; end
      end
      vectors++; if (done_cyc !== 20) begin errors++; $display("FAIL tmo_done_cycle got %0d want 20", done_cyc); end
      vectors++; if (err_at !== 1'b1 || rd_at !== 8'hFF) begin errors++; $display("FAIL tmo_err got err=%b rdata=%h want 1/ff", err_at, rd_at); end
      step();
      vectors++; if (bif.ERR !== 1'b0 || bif.DONE !== 1'b0) begin errors++; $display("FAIL tmo_clear got err=%b done=%b want 0/0", bif.ERR, bif.DONE); end
    end
`else
    begin
      int dcount;
      dcount = 0;
      for (int i = 1; i <= 100; i++) begin
        step();
        if (i == 1) bif.REQ = 1'b0;
        if (bif.DONE === 1'b1) dcount++;
      end
      vectors++; if (dcount !== 0) begin errors++; $display("FAIL tmo_none got %0d done pulses want 0", dcount); end
      vectors++; if (ctl() !== 8'b0011_1100) begin errors++; $display("FAIL tmo_stuck_ctl got %b want %b", ctl(), 8'b0011_1100); end
      bif.READY = 1'b1;
      step();
      vectors++; if (ctl() !== 8'b0111_0110 || bif.RDATA !== 8'h12) begin errors++; $display("FAIL tmo_release got ctl=%b rdata=%h want 01110110/12", ctl(), bif.RDATA); end
      step();
    end
`endif
  endtask

  initial begin
    bif.REQ = 1'b0; bif.REQ_WR = 1'b0; bif.REQ_MEM = 1'b0;
    bif.REQ_ADDR = '0; bif.REQ_WDATA = '0; bif.READY = 1'b1; bif.Data = '0;
    rst_n = 1'b0;
    test_reset();
    test_mem_write();
    test_io_read();
    test_write_keeps_rdata();
    test_wait_states();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
